opal_rx_lanes: RTL and testbench

Parametrised receiver for the OPAL-RT digital-out link. It runs on the FPGA system clock and oversamples an asynchronous strobe clock, a frame enable and `LANES` serial data lines. It deserialises one `VAR_WIDTH`-bit variable per lane per frame and presents each complete frame as a single atomic word on a valid/ready output. Frame errors are detected, counted and exposed for the AXI-lite register block.

---
 rtl/opal_rx_lanes.sv | 178 +++++++++++++++++
 tb/tb_opal_rx_lanes.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/opal_rx_lanes.sv
// OPAL-RT digital-out link receiver: oversamples strobe/enable/data lanes, deserialises
// one VAR_WIDTH-bit variable per lane per frame and hands each frame out on valid/ready.
module opal_rx_lanes #(
  parameter int LANES     = 16,
  parameter int VAR_WIDTH = 16,
  parameter bit MSB_FIRST = 1'b1,
  parameter int TIMEOUT   = 1024
) (
  input  logic                       CLK100MHz,
  input  logic                       ARESET,
  input  logic                       i_opal_clk,
  input  logic                       i_opal_en,
  input  logic [LANES-1:0]           i_opal_data,
  output logic [LANES*VAR_WIDTH-1:0] o_data,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [15:0]                o_frame_cnt,
  output logic [7:0]                 o_err_cnt,
  output logic                       o_overrun,
  input  logic                       i_clear,
  output logic [3:0]                 o_state
);

  localparam int BW = $clog2(VAR_WIDTH + 1);

  typedef logic [VAR_WIDTH-1:0] var_t;

  typedef enum logic [3:0] {
    S_IDLE  = 4'b0001,
    S_SHIFT = 4'b0010,
    S_DONE  = 4'b0100,
    S_ERR   = 4'b1000
  } state_e;

  state_e                   state_q, state_d;
  logic [2:0]               clk_s_q, clk_s_d;
  logic [1:0]               en_s_q, en_s_d;
  logic [LANES-1:0]         data_s1_q, data_s1_d;
  logic [LANES-1:0]         data_s2_q, data_s2_d;
  logic [1:0]               warm_q, warm_d;
  logic                     armed_q, armed_d;
  logic [LANES-1:0][VAR_WIDTH-1:0] sh_q, sh_d;
  logic [LANES-1:0][VAR_WIDTH-1:0] data_q, data_d;
  logic [BW-1:0]            bcnt_q, bcnt_d;
  logic [15:0]              wd_q, wd_d;
  logic                     valid_q, valid_d;
  logic [15:0]              frame_q, frame_d;
  logic [7:0]               err_q, err_d;
  logic                     ovr_q, ovr_d;

  logic rise;
  logic en_sync;
  logic bcnt_full;

  assign rise      = clk_s_q[1] & ~clk_s_q[2];
  assign en_sync   = en_s_q[1];
  assign bcnt_full = (bcnt_q == BW'(VAR_WIDTH));

  function automatic var_t shift_in(input var_t cur, input logic b);
    if (MSB_FIRST) return {cur[VAR_WIDTH-2:0], b};
    else           return {b, cur[VAR_WIDTH-1:1]};
  endfunction

  always_comb begin
    // NOTE: every _d gets a default before any branch so no path can infer a latch.
    state_d   = state_q;
    clk_s_d   = {clk_s_q[1:0], i_opal_clk};
    en_s_d    = {en_s_q[0], i_opal_en};
    data_s1_d = i_opal_data;
    data_s2_d = data_s1_q;
    warm_d    = {warm_q[0], 1'b1};
    armed_d   = armed_q;
    sh_d      = sh_q;
    data_d    = data_q;
    bcnt_d    = bcnt_q;
    wd_d      = '0;
    valid_d   = valid_q;
    frame_d   = frame_q;
    err_d     = err_q;
    ovr_d     = ovr_q;

    // Only arm once the synchronisers hold real pin samples and enable is seen low,
    // so a frame already running when reset lifts is ignored.
    if (warm_q[1] && !en_sync) armed_d = 1'b1;

    if (valid_q && i_ready) valid_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (armed_q && en_sync && rise) begin
          for (int k = 0; k < LANES; k++) sh_d[k] = shift_in('0, data_s2_q[k]);
          bcnt_d  = BW'(1);
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        wd_d = wd_q + 16'd1;
        if (!en_sync) begin
          state_d = bcnt_full ? S_DONE : S_ERR;
        end else if (rise) begin
          wd_d = '0;
          if (bcnt_full) begin
            state_d = S_ERR;
          end else begin
            for (int k = 0; k < LANES; k++) sh_d[k] = shift_in(sh_q[k], data_s2_q[k]);
            bcnt_d = bcnt_q + BW'(1);
          end
        end else if (wd_q == 16'(TIMEOUT - 1)) begin
          state_d = S_ERR;
        end
      end
      S_DONE: begin
        data_d  = sh_q;
        valid_d = 1'b1;
        frame_d = frame_q + 16'd1;
        if (valid_q && !i_ready) ovr_d = 1'b1;
        state_d = S_IDLE;
      end
      S_ERR: begin
        if (!en_sync) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_ERR && state_q != S_ERR && err_q != 8'hFF) err_d = err_q + 8'd1;

    if (i_clear) begin
      err_d = '0;
      ovr_d = 1'b0;
    end
  end

  always_ff @(posedge CLK100MHz or posedge ARESET) begin
    // NOTE: the shift registers are datapath storage, but they are reset too so a frame
    // cut short by reset can never leak stale bits into a later word.
    if (ARESET) begin
      state_q   <= S_IDLE;
      clk_s_q   <= '0;
      en_s_q    <= '0;
      data_s1_q <= '0;
      data_s2_q <= '0;
      warm_q    <= '0;
      armed_q   <= 1'b0;
      sh_q      <= '0;
      data_q    <= '0;
      bcnt_q    <= '0;
      wd_q      <= '0;
      valid_q   <= 1'b0;
      frame_q   <= '0;
      err_q     <= '0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      clk_s_q   <= clk_s_d;
      en_s_q    <= en_s_d;
      data_s1_q <= data_s1_d;
      data_s2_q <= data_s2_d;
      warm_q    <= warm_d;
      armed_q   <= armed_d;
      sh_q      <= sh_d;
      data_q    <= data_d;
      bcnt_q    <= bcnt_d;
      wd_q      <= wd_d;
      valid_q   <= valid_d;
      frame_q   <= frame_d;
      err_q     <= err_d;
      ovr_q     <= ovr_d;
    end
  end

  assign o_data      = data_q;
  assign o_valid     = valid_q;
  assign o_frame_cnt = frame_q;
  assign o_err_cnt   = err_q;
  assign o_overrun   = ovr_q;
  assign o_state     = state_q;

endmodule

// File: tb/tb_opal_rx_lanes.sv
// Directed bench for opal_rx_lanes: an MSB-first and an LSB-first instance receive the
// same words (each in its own bit order) and must both match the hand-computed results.
module tb_opal_rx_lanes;

  localparam int TO = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        oclk, oen, ready, clear;
  logic [1:0]  data_m, data_l;

  logic [31:0] od_m, od_l;
  logic        ov_m, ov_l, ovr_m, ovr_l;
  logic [15:0] fc_m, fc_l;
  logic [7:0]  ec_m, ec_l;
  logic [3:0]  st_m, st_l;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  opal_rx_lanes #(.LANES(2), .VAR_WIDTH(16), .MSB_FIRST(1'b1), .TIMEOUT(TO)) dut_m (
    .CLK100MHz(clk), .ARESET(rst), .i_opal_clk(oclk), .i_opal_en(oen),
    .i_opal_data(data_m), .o_data(od_m), .o_valid(ov_m), .i_ready(ready),
    .o_frame_cnt(fc_m), .o_err_cnt(ec_m), .o_overrun(ovr_m), .i_clear(clear),
    .o_state(st_m));

  opal_rx_lanes #(.LANES(2), .VAR_WIDTH(16), .MSB_FIRST(1'b0), .TIMEOUT(TO)) dut_l (
    .CLK100MHz(clk), .ARESET(rst), .i_opal_clk(oclk), .i_opal_en(oen),
    .i_opal_data(data_l), .o_data(od_l), .o_valid(ov_l), .i_ready(ready),
    .o_frame_cnt(fc_l), .o_err_cnt(ec_l), .o_overrun(ovr_l), .i_clear(clear),
    .o_state(st_l));

  typedef struct {
    logic [15:0] w0;
    logic [15:0] w1;
    int          nbits;
    logic        rdy;
    logic [31:0] e_data;
    logic        e_valid;
    logic [15:0] e_frames;
    logic [7:0]  e_err;
    logic        e_ovr;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic bit_of(input logic [15:0] w, input int j, input bit msb);
    if (j > 15) return 1'b0;
    return msb ? w[4'(15 - j)] : w[4'(j)];
  endfunction

  task automatic send_bit(input logic [15:0] w0, input logic [15:0] w1, input int j);
    data_m = {bit_of(w1, j, 1'b1), bit_of(w0, j, 1'b1)};
    data_l = {bit_of(w1, j, 1'b0), bit_of(w0, j, 1'b0)};
    oclk   = 1'b1;
    tick(5);
    oclk   = 1'b0;
    tick(5);
  endtask

  task automatic send_bits(input logic [15:0] w0, input logic [15:0] w1,
                           input int first, input int count);
    oen = 1'b1;
    if (first == 0) tick(4);
    for (int j = first; j < first + count; j++) send_bit(w0, w1, j);
  endtask

  task automatic check_outs(input string tag, input logic [31:0] d, input logic v,
                            input logic [15:0] f, input logic [7:0] e, input logic o);
    check({tag, " data_m"},  od_m, d);
    check({tag, " data_l"},  od_l, d);
    check({tag, " valid_m"}, 32'(ov_m), 32'(v));
    check({tag, " valid_l"}, 32'(ov_l), 32'(v));
    check({tag, " frames_m"}, 32'(fc_m), 32'(f));
    check({tag, " frames_l"}, 32'(fc_l), 32'(f));
    check({tag, " err_m"},   32'(ec_m), 32'(e));
    check({tag, " err_l"},   32'(ec_l), 32'(e));
    check({tag, " ovr_m"},   32'(ovr_m), 32'(o));
    check({tag, " ovr_l"},   32'(ovr_l), 32'(o));
  endtask

  task automatic check_state(input string tag, input logic [3:0] s);
    check({tag, " state_m"}, 32'(st_m), 32'(s));
    check({tag, " state_l"}, 32'(st_l), 32'(s));
  endtask

  task automatic run_vec(input int i);
    ready = vecs[i].rdy;
    send_bits(vecs[i].w0, vecs[i].w1, 0, vecs[i].nbits);
    oen = 1'b0;
    tick(10);
    check_outs($sformatf("vec%0d", i), vecs[i].e_data, vecs[i].e_valid,
               vecs[i].e_frames, vecs[i].e_err, vecs[i].e_ovr);
  endtask

  initial begin
    #2ms;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    //           w0        w1       n   rdy  data           v     frm    err   ovr
    vecs[0] = '{16'hA5C3, 16'h0F0F, 16, 1'b1, 32'h0F0FA5C3, 1'b0, 16'd1, 8'd0, 1'b0};
    vecs[1] = '{16'h1234, 16'h5678, 12, 1'b1, 32'h0F0FA5C3, 1'b0, 16'd1, 8'd1, 1'b0};
    vecs[2] = '{16'hFFFF, 16'h0000, 17, 1'b1, 32'h0F0FA5C3, 1'b0, 16'd1, 8'd2, 1'b0};
    vecs[3] = '{16'h8001, 16'h7FFE, 16, 1'b1, 32'h7FFE8001, 1'b0, 16'd2, 8'd2, 1'b0};
    vecs[4] = '{16'hDEAD, 16'hBEEF, 16, 1'b0, 32'hBEEFDEAD, 1'b1, 16'd3, 8'd2, 1'b0};
    vecs[5] = '{16'hCAFE, 16'hF00D, 16, 1'b0, 32'hF00DCAFE, 1'b1, 16'd4, 8'd2, 1'b1};
    vecs[6] = '{16'h0001, 16'h8000, 16, 1'b1, 32'h80000001, 1'b0, 16'd5, 8'd0, 1'b0};
    vecs[7] = '{16'h5555, 16'hAAAA, 16, 1'b1, 32'hAAAA5555, 1'b0, 16'd6, 8'd0, 1'b0};

    rst = 1'b1; oclk = 1'b0; oen = 1'b0; ready = 1'b0; clear = 1'b0;
    data_m = '0; data_l = '0;
    tick(3);
    check_outs("reset", 32'h0, 1'b0, 16'd0, 8'd0, 1'b0);
    check_state("reset", 4'b0001);
    rst = 1'b0;
    tick(4);

    for (int i = 0; i < 6; i++) run_vec(i);

    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    check_outs("clear", 32'hF00DCAFE, 1'b1, 16'd4, 8'd0, 1'b0);

    for (int i = 6; i < 8; i++) run_vec(i);

    // Enable-fall to o_valid latency: pin changes at a negedge, so valid rises on the 4th edge.
    ready = 1'b0;
    send_bits(16'h1357, 16'h2468, 0, 16);
    oen = 1'b0;
    tick(3);
    check("latency valid_m_e3", 32'(ov_m), 32'd0);
    check("latency valid_l_e3", 32'(ov_l), 32'd0);
    tick(1);
    check_outs("latency", 32'h24681357, 1'b1, 16'd7, 8'd0, 1'b0);
    tick(6);

    // ready only during the DONE cycle: handshake and reload coincide, no overrun.
    send_bits(16'h9ABC, 16'hDEF0, 0, 16);
    oen = 1'b0;
    tick(3);
    ready = 1'b1;
    tick(1);
    ready = 1'b0;
    check_outs("coincide", 32'hDEF09ABC, 1'b1, 16'd8, 8'd0, 1'b0);
    tick(6);
    ready = 1'b1;
    tick(2);
    check("consume valid_m", 32'(ov_m), 32'd0);
    check("consume valid_l", 32'(ov_l), 32'd0);

    // Strobe stops after 5 bits: ERR lands exactly TO edges after the edge registering the last rise.
    send_bits(16'hFFFF, 16'hFFFF, 0, 5);
    tick(TO - 8);
    check_state("wd_before", 4'b0010);
    tick(1);
    check_state("wd_err", 4'b1000);
    check("wd err_m", 32'(ec_m), 32'd1);
    check("wd err_l", 32'(ec_l), 32'd1);
    oen = 1'b0;
    tick(10);
    check_state("wd_idle", 4'b0001);
    check_outs("wd_after", 32'hDEF09ABC, 1'b0, 16'd8, 8'd1, 1'b0);
    send_bits(16'h4321, 16'h8765, 0, 16);
    oen = 1'b0;
    tick(10);
    check_outs("wd_recover", 32'h87654321, 1'b0, 16'd9, 8'd1, 1'b0);

    // Reset in the middle of a frame, released while that frame is still running.
    ready = 1'b0;
    send_bits(16'hAAAA, 16'h5555, 0, 8);
    rst = 1'b1;
    #1;
    check_outs("rst_mid", 32'h0, 1'b0, 16'd0, 8'd0, 1'b0);
    check_state("rst_mid", 4'b0001);
    tick(1);
    rst = 1'b0;
    send_bits(16'hAAAA, 16'h5555, 8, 8);
    oen = 1'b0;
    tick(10);
    check_outs("rst_ignored", 32'h0, 1'b0, 16'd0, 8'd0, 1'b0);
    check_state("rst_ignored", 4'b0001);
    ready = 1'b1;
    send_bits(16'h0F0F, 16'hF0F0, 0, 16);
    oen = 1'b0;
    tick(10);
    check_outs("rst_next", 32'hF0F00F0F, 1'b0, 16'd1, 8'd0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
